// File: rtl/keccak_byte_padder.sv
// Byte-serial Keccak absorb front end: packs bytes into 576-bit rate blocks,
// applies multi-rate padding and hands each block to the permutation.
module keccak_byte_padder #(
  parameter logic [7:0] PAD_BYTE = 8'h06
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [575:0] out,
  output logic         out_valid,
  output logic         out_last,
  input  logic         f_ack
);

  typedef enum logic {FILL, FULL} st_t;

  localparam logic [575:0] PAD_BLK = {PAD_BYTE, 560'd0, 8'h80};

  st_t          st_q;
  logic [575:0] buf_q;
  logic [6:0]   cnt_q;
  logic         extra_q;
  logic         last_q;

  logic [9:0]   pos;
  logic [575:0] wr_blk_d;

  // Byte k lives at bits [575-8k -: 8]; first byte of the block is the MSB byte.
  assign pos = 10'd575 - {cnt_q, 3'b000};

  always_comb begin
    wr_blk_d = buf_q;
    wr_blk_d[pos -: 8] = in_byte;
    if (in_last && (cnt_q != 7'd71)) begin
      wr_blk_d[(pos - 10'd8) -: 8] = wr_blk_d[(pos - 10'd8) -: 8] | PAD_BYTE;
      wr_blk_d[7:0] = wr_blk_d[7:0] | 8'h80;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      extra_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (st_q)
        FILL: if (in_valid) begin
          buf_q <= wr_blk_d;
          if (cnt_q == 7'd71) begin
            // A last byte filling the block leaves a pad-only block owed.
            st_q    <= FULL;
            last_q  <= 1'b0;
            extra_q <= in_last;
          end else if (in_last) begin
            st_q    <= FULL;
            last_q  <= 1'b1;
            extra_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        FULL: if (f_ack) begin
          if (extra_q) begin
            buf_q   <= PAD_BLK;
            last_q  <= 1'b1;
            extra_q <= 1'b0;
          end else begin
            buf_q  <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
            st_q   <= FILL;
          end
        end
        default: st_q <= FILL;
      endcase
    end
  end

  assign in_ready  = (st_q == FILL);
  assign out_valid = (st_q == FULL);
  assign out       = buf_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_keccak_byte_padder.sv
// Self-checking bench for keccak_byte_padder: directed scenarios plus random
// messages, compared against a padded-byte-stream reference model.
module tb_keccak_byte_padder;
  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_byte;
  logic         in_valid, in_last, in_ready;
  logic [575:0] out;
  logic         out_valid, out_last, f_ack;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] q[$];

  keccak_byte_padder #(.PAD_BYTE(8'h06)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_last(out_last), .f_ack(f_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Model: message, then PAD_BYTE, zero fill to a 72-byte multiple, 0x80 OR'd into the final byte.
  task automatic transact(input string tag, input logic [7:0] msg[$], input int dmin, input int dmax);
    logic [7:0]   exp[$];
    logic [575:0] eb, held;
    int i = 0, blk = 0, nblk, wait_c = 0, guard = 0;
    bit seen = 0, exp_full = 0;
    exp = msg;
    exp.push_back(8'h06);
    while (exp.size() % 72 != 0) exp.push_back(8'h00);
    exp[exp.size()-1] = exp[exp.size()-1] | 8'h80;
    nblk = exp.size() / 72;
    eb = '0; held = '0;
    while (blk < nblk && guard < 20000) begin
      @(negedge clk);
      guard++;
      f_ack = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'($urandom);
      if (exp_full) begin
        chk1({tag, " valid_latency"}, out_valid, 1'b1);
        exp_full = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          eb = '0;
          for (int k = 0; k < 72; k++) eb[575-8*k -: 8] = exp[blk*72+k];
          chk({tag, " block"}, out, eb);
          chk1({tag, " out_last"}, out_last, (blk == nblk-1));
          chk1({tag, " in_ready_full"}, in_ready, 1'b0);
          held = out; seen = 1;
          wait_c = $urandom_range(dmax, dmin);
        end else begin
          chk({tag, " stable"}, out, held);
          chk1({tag, " in_ready_hold"}, in_ready, 1'b0);
        end
        // Source keeps presenting its pending byte; it must be ignored.
        if (i < msg.size()) begin
          in_valid = 1'b1; in_byte = msg[i]; in_last = (i == msg.size()-1);
        end
        if (wait_c == 0) begin
          f_ack = 1'b1; blk++; seen = 0;
          if (blk < nblk && i == msg.size()) exp_full = 1;
        end else wait_c--;
      end else begin
        chk1({tag, " in_ready_fill"}, in_ready, 1'b1);
        f_ack = 1'($urandom_range(0, 1));
        if (i < msg.size() && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1; in_byte = msg[i]; in_last = (i == msg.size()-1);
          if ((i % 72 == 71) || in_last) exp_full = 1;
          i++;
        end
      end
    end
    chk1({tag, " no_timeout"}, (blk == nblk), 1'b1);
    @(negedge clk);
    f_ack = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk1({tag, " in_ready_after_ack"}, in_ready, 1'b1);
    chk1({tag, " out_valid_after_ack"}, out_valid, 1'b0);
    chk({tag, " cleared"}, out, '0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00; f_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst in_ready", in_ready, 1'b1);
    chk1("rst out_valid", out_valid, 1'b0);
    chk1("rst out_last", out_last, 1'b0);
    chk("rst out", out, '0);
    reset = 1'b0;

    q = '{8'h61, 8'h62, 8'h63};
    transact("abc", q, 0, 0);

    q.delete(); repeat (71) q.push_back(8'hAA);
    transact("aa71", q, 0, 2);

    q.delete(); repeat (72) q.push_back(8'h55);
    transact("x55_72", q, 0, 2);

    q.delete(); repeat (144) q.push_back(8'($urandom)); q.push_back(8'h01);
    transact("b145", q, 0, 3);

    q.delete(); repeat (80) q.push_back(8'($urandom));
    transact("bkpr", q, 10, 10);

    // Reset mid-block, then the "abc" block must come out clean.
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_last = 1'b0; in_byte = 8'($urandom) | 8'h01;
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst out", out, '0);
    chk1("midrst in_ready", in_ready, 1'b1);
    chk1("midrst out_valid", out_valid, 1'b0);
    q = '{8'h61, 8'h62, 8'h63};
    transact("abc_after_rst", q, 0, 0);

    for (int m = 0; m < 6; m++) begin
      q.delete();
      repeat ($urandom_range(200, 1)) q.push_back(8'($urandom));
      transact($sformatf("rnd%0d", m), q, 0, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keccak_byte_padder.md
# keccak_byte_padder

Byte-serial absorb front end for the Keccak core: collects message bytes from the UART receive path, packs them into 576-bit rate blocks, applies Keccak multi-rate padding, and presents each block to `f_permutation` on its `in`/`in_ready`/`ack` handshake. It sits directly upstream of `f_permutation`. It holds exactly one block buffer and back-pressures the byte source while a block waits to be absorbed.

## Interface
- `PAD_BYTE`, default `8'h06`: domain/padding byte inserted after the last message byte. Use `8'h01` for legacy Keccak.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_byte`  in  8  message byte
- `in_valid`  in  1  `in_byte` is valid this cycle
- `in_last`  in  1  qualifies `in_valid`: this byte ends the message
- `in_ready`  out  1  block accepts a byte this cycle; transfer occurs when `in_valid & in_ready`
- `out`  out  576  padded rate block; drives `f_permutation.in`
- `out_valid`  out  1  `out` holds a complete block; drives `f_permutation.in_ready`
- `out_last`  out  1  the presented block is the final block of the message; valid while `out_valid`
- `f_ack`  in  1  `f_permutation.ack`; the block is consumed this cycle

## Operation
- Byte order: byte index k (0..71, first byte of the block = 0) occupies `out[575-8k -: 8]`.
- State: buffer `buf[575:0]`, byte counter `cnt` (7 bits, 0..71), state `st` ∈ {FILL, FULL}, flag `extra` (a pad-only block is still owed), flag `last`.
- FILL: `in_ready=1`, `out_valid=0`. On transfer, write `in_byte` to index `cnt`.
  - Non-last byte with `cnt<71`: `cnt<=cnt+1`, stay in FILL.
  - Non-last byte with `cnt==71`: go to FULL, `last<=0`.
  - Last byte with `cnt<71`: in the same cycle, also OR `PAD_BYTE` into index `cnt+1` and OR `8'h80` into index 71. If `cnt==70`, index 71 becomes `PAD_BYTE|8'h80` (`8'h86`). Go to FULL with `last<=1` and `extra<=0`.
  - Last byte with `cnt==71`: go to FULL with `last<=0` and `extra<=1`.
- FULL: `in_ready=0`, `out_valid=1`, `out=buf`, `out_last=last`.
  - On `f_ack` with `extra=1`: load a pad-only block (`PAD_BYTE` at index 0, zeros, `8'h80` at index 71), set `last<=1` and `extra<=0`, stay in FULL.
  - On `f_ack` with `extra=0`: clear `buf` to zero, set `cnt<=0` and `last<=0`, return to FILL.
- Indices above the last written byte are always zero, because `buf` is cleared on every block hand-off.
- Zero-length messages are not supported; every message carries at least one byte with `in_last`.
- Between messages, the top level resets the `f_permutation` state. This block only marks the final block with `out_last`.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_last=0`, `out=0`, `cnt=0`, `st=FILL`, `extra=0`.
- A reset in any state discards the partial or pending block; the next cycle is FILL with an empty buffer.
- A byte accepted in cycle n that completes or terminates a block gives `out_valid=1` in cycle n+1.
- `f_ack` may be asserted in the first cycle `out_valid` is high, since `f_permutation` acks combinationally when idle.
- After `f_ack` in cycle m:
  - With `extra=1`: the pad-only block is on `out` in cycle m+1.
  - Otherwise: `in_ready=1` in cycle m+1.
- While `out_valid=1` and `f_ack=0`, `out` and `out_last` are held stable. `f_permutation` only acks between 24-cycle permutations.
- `in_ready` is registered-state-derived only and has no combinational path from `in_valid` or `f_ack`.
- `f_ack` while `out_valid=0` is ignored.
- `in_valid` while `in_ready=0` is ignored. The source must hold its byte.
- Sustained throughput: 72 bytes per block plus 1 or more cycles of hand-off.

## Test plan
- Send "abc" (`0x61`, `0x62`, `0x63`+last), with `f_ack` returned on the first `out_valid` cycle.
  - One block: `out[575:544]=0x61626306`, indices 4..70 zero, `out[7:0]=0x80`, `out_last=1`.
  - `in_ready=1` the next cycle.
- Send 71 bytes of `0xAA`, the 71st with last.
  - One block: indices 0..70 are `0xAA`, index 71 is `0x86`, `out_last=1`.
- Send 72 bytes of `0x55`, the 72nd with last.
  - Block 1: all `0x55`, `out_last=0`.
  - After `f_ack`, block 2 (next cycle): `out[575:568]=0x06`, `out[7:0]=0x80`, rest zero, `out_last=1`.
- Send 144 bytes (not last), then 1 byte `0x01`+last.
  - Three blocks, with `out_last` only on the third.
  - Third block: `out[575:560]=0x0106`, `out[7:0]=0x80`.
- Backpressure: complete a block and hold `f_ack=0` for 10 cycles while driving `in_valid=1`.
  - `in_ready=0` and `out` stable throughout.
  - No byte is lost after `f_ack`.
- Assert reset after 30 bytes of a block, then send "abc".
  - The output block is identical to the first scenario, with no stale bytes.
